regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32 x 32-bit MIPS register file. Two producers share the register file's single write port: the ALU result path and the load path (LB/LH/LW/LBU/LHU). The block grants the port round-robin, formats load data by opcode, suppresses writes to r0, and tracks pending destination registers so the decode stage can detect read-after-write hazards on rs/rt.

---
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter and pending-register scoreboard for the 32 x 32-bit
//   MIPS register file. The ALU result path and the load path share the
//   single register-file write port. Grants alternate round-robin when both
//   request. Load data is formatted by opcode. Writes to r0 are swallowed.
//   A busy vector marks destination registers with a write still in flight.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       ALU write-back request
//   alu_ready                       ALU request accepted this cycle (comb)
//   ld_valid/ld_rt/ld_data/ld_opcode  load write-back request
//   ld_ready                        load request accepted this cycle (comb)
//   alloc_valid/alloc_reg           decode allocates a destination register
//   rs, rt / rs_busy, rt_busy       hazard lookup of decode source registers
//   wr_en/wr_addr/wr_data           registered register-file write port
//   ld_op_err                       one-cycle pulse with wr_en: unknown load opcode
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rt,
    input  logic [31:0] ld_data,
    input  logic [5:0]  ld_opcode,
    output logic        ld_ready,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_reg,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        ld_op_err
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LD  = 1'b1
    } grant_t;

    grant_t      r_last_grant;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_op_err;
    logic [31:0] r_busy;

    logic        w_alu_acc;
    logic        w_ld_acc;
    logic [31:0] w_ld_fmt;
    logic        w_ld_bad;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

    // ALU wins when alone or when the load path was granted last.
    assign w_alu_acc = alu_valid & (~ld_valid | (r_last_grant == GRANT_LD));
    assign w_ld_acc  = ld_valid & ~w_alu_acc;

    assign alu_ready = w_alu_acc;
    assign ld_ready  = w_ld_acc;

    always_comb begin
        w_ld_fmt = ld_data;
        w_ld_bad = 1'b0;
        case (ld_opcode)
            6'h20:   w_ld_fmt = {{24{ld_data[7]}}, ld_data[7:0]};
            6'h21:   w_ld_fmt = {{16{ld_data[15]}}, ld_data[15:0]};
            6'h23:   w_ld_fmt = ld_data;
            6'h24:   w_ld_fmt = {24'd0, ld_data[7:0]};
            6'h25:   w_ld_fmt = {16'd0, ld_data[15:0]};
            default: w_ld_bad = 1'b1;
        endcase
    end

    // Arbitration pointer and registered write port. Address/data hold
    // their previous values on cycles without a write (including r0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_LD;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_op_err     <= 1'b0;
        end else begin
            r_wr_en  <= 1'b0;
            r_op_err <= 1'b0;
            if (w_alu_acc) begin
                r_last_grant <= GRANT_ALU;
                if (alu_rd != 5'd0) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= alu_rd;
                    r_wr_data <= alu_data;
                end
            end else if (w_ld_acc) begin
                r_last_grant <= GRANT_LD;
                if (ld_rt != 5'd0) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= ld_rt;
                    r_wr_data <= w_ld_fmt;
                    r_op_err  <= w_ld_bad;
                end
            end
        end
    end

    // Set is applied after clear so a same-cycle re-allocation stays busy.
    assign w_busy_set = (alloc_valid && alloc_reg != 5'd0) ? (32'd1 << alloc_reg) : '0;
    assign w_busy_clr = r_wr_en ? (32'd1 << r_wr_addr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign rs_busy   = r_busy[rs];
    assign rt_busy   = r_busy[rt];
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign ld_op_err = r_op_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed and random stimulus for regfile_wb_arbiter, checked against a
//   transaction-level reference model held in the bench.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rt;
    logic [31:0] ld_data;
    logic [5:0]  ld_opcode;
    logic        ld_ready;
    logic        alloc_valid;
    logic [4:0]  alloc_reg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_busy;
    logic        rt_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ld_op_err;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rt(ld_rt), .ld_data(ld_data), .ld_opcode(ld_opcode),
        .ld_ready(ld_ready),
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
        .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ld_op_err(ld_op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_prev_was_load;
    bit          m_busy [0:31];
    bit          m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    bit          m_err;
    bit          m_acc_alu;
    bit          m_acc_ld;
    logic        obs_alu_ready;
    logic        obs_ld_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_known(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    endfunction

    function automatic logic [31:0] ref_fmt(input logic [5:0] op, input logic [31:0] d);
        byte     sb;
        shortint sh;
        sb = d[7:0];
        sh = d[15:0];
        case (op)
            6'h20:   return 32'(int'(sb));
            6'h21:   return 32'(int'(sh));
            6'h24:   return d % 256;
            6'h25:   return d % 65536;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_prev_was_load = 1'b1;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_err     = 1'b0;
    endtask

    task automatic clear_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rt = 0; ld_data = 0; ld_opcode = 0;
        alloc_valid = 0; alloc_reg = 0; rs = 0; rt = 0;
    endtask

    // One clock cycle: inputs are already driven (just after a rising edge).
    task automatic step();
        bit take_alu, take_ld;
        #2;
        take_alu = alu_valid && (!ld_valid || m_prev_was_load);
        take_ld  = ld_valid && !take_alu;
        obs_alu_ready = alu_ready;
        obs_ld_ready  = ld_ready;
        chk("alu_ready", alu_ready, take_alu);
        chk("ld_ready", ld_ready, take_ld);
        chk("rs_busy_pre", rs_busy, m_busy[rs]);
        chk("rt_busy_pre", rt_busy, m_busy[rt]);
        if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
        if (alloc_valid && alloc_reg != 0) m_busy[alloc_reg] = 1'b1;
        m_wr_en = 1'b0;
        m_err   = 1'b0;
        if (take_alu) begin
            m_prev_was_load = 1'b0;
            if (alu_rd != 0) begin
                m_wr_en = 1'b1; m_wr_addr = alu_rd; m_wr_data = alu_data;
            end
        end else if (take_ld) begin
            m_prev_was_load = 1'b1;
            if (ld_rt != 0) begin
                m_wr_en = 1'b1; m_wr_addr = ld_rt; m_wr_data = ref_fmt(ld_opcode, ld_data);
                m_err = !ref_known(ld_opcode);
            end
        end
        m_acc_alu = take_alu;
        m_acc_ld  = take_ld;
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_addr", wr_addr, m_wr_addr);
        chk("wr_data", wr_data, m_wr_data);
        chk("ld_op_err", ld_op_err, m_err);
        chk("rs_busy_post", rs_busy, m_busy[rs]);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_op_err", ld_op_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    bit          p_alu, p_ld;
    logic [4:0]  p_alu_rd, p_ld_rt;
    logic [31:0] p_alu_data, p_ld_data;
    logic [5:0]  p_ld_op;
    logic [5:0]  ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h22, 6'h00, 6'h3F};

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("por_wr_en", wr_en, 0);
        chk("por_wr_data", wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both valid for 4 cycles -> ALU, load, ALU, load
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h1111_2222;
        ld_valid = 1; ld_rt = 5'd4; ld_opcode = 6'h23; ld_data = 32'hA5A5_0001;
        step(); chk("tie1_alu", obs_alu_ready, 1); chk("tie1_addr", wr_addr, 3);
        step(); chk("tie2_ld", obs_ld_ready, 1); chk("tie2_addr", wr_addr, 4);
        step(); chk("tie3_alu", obs_alu_ready, 1); chk("tie3_en", wr_en, 1);
        step(); chk("tie4_ld", obs_ld_ready, 1); chk("tie4_en", wr_en, 1);
        clear_inputs();

        // Single LBU
        ld_valid = 1; ld_rt = 5'd14; ld_opcode = 6'h24; ld_data = 32'h0054_B02B;
        step();
        chk("lbu_ready", obs_ld_ready, 1);
        chk("lbu_en", wr_en, 1); chk("lbu_addr", wr_addr, 14); chk("lbu_data", wr_data, 32'h0000_002B);

        // Sign handling
        ld_rt = 5'd1; ld_opcode = 6'h20; ld_data = 32'h0000_00F0;
        step(); chk("lb_data", wr_data, 32'hFFFF_FFF0);
        ld_opcode = 6'h21; ld_data = 32'h0000_8001;
        step(); chk("lh_data", wr_data, 32'hFFFF_8001);
        ld_opcode = 6'h25;
        step(); chk("lhu_data", wr_data, 32'h0000_8001);
        clear_inputs();

        // r0 suppression
        ld_valid = 1; ld_rt = 5'd0; ld_opcode = 6'h25; ld_data = 32'h1234_5678;
        step(); chk("r0_ld_ready", obs_ld_ready, 1); chk("r0_ld_en", wr_en, 0);
        clear_inputs();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hCAFE_F00D; alloc_valid = 1; alloc_reg = 5'd0;
        step(); chk("r0_alu_ready", obs_alu_ready, 1); chk("r0_alu_en", wr_en, 0);
        clear_inputs();
        step(); chk("r0_rs_busy", rs_busy, 0); chk("r0_hold_data", wr_data, 32'h0000_8001);

        // Scoreboard
        alloc_valid = 1; alloc_reg = 5'd5; rs = 5'd5;
        step(); chk("sb_set", rs_busy, 1);
        alloc_valid = 0; alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h0000_0055;
        step(); chk("sb_wr", wr_en, 1); chk("sb_still", rs_busy, 1);
        alu_valid = 0;
        step(); chk("sb_clr", rs_busy, 0);
        alloc_valid = 1; alloc_reg = 5'd5;
        step();
        alloc_valid = 0; alu_valid = 1; alu_rd = 5'd5;
        step();
        alu_valid = 0; alloc_valid = 1; alloc_reg = 5'd5;
        step(); chk("sb_realloc", rs_busy, 1);
        clear_inputs();

        // Unknown opcode
        ld_valid = 1; ld_rt = 5'd7; ld_opcode = 6'h22; ld_data = 32'hDEAD_BEEF;
        step(); chk("bad_err", ld_op_err, 1); chk("bad_data", wr_data, 32'hDEAD_BEEF);
        clear_inputs();
        step(); chk("bad_pulse", ld_op_err, 0);

        // Reset during the wr_en cycle of a write to r9 with busy[9] set
        alloc_valid = 1; alloc_reg = 5'd9; rs = 5'd9;
        step();
        alloc_valid = 0; alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h9999_0009;
        step(); chk("mid_en", wr_en, 1); chk("mid_busy", rs_busy, 1);
        #2;
        apply_reset();
        rs = 5'd9;
        #1; chk("mid_busy_rst", rs_busy, 0);
        alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2;
        ld_valid = 1; ld_rt = 5'd3; ld_opcode = 6'h23; ld_data = 32'h3;
        step(); chk("post_rst_tie", obs_alu_ready, 1);
        clear_inputs();
        step();

        // Random traffic with sources holding requests until accepted
        p_alu = 0; p_ld = 0;
        for (int n = 0; n < 600; n++) begin
            if (!p_alu && $urandom_range(0, 2) != 0) begin
                p_alu = 1; p_alu_rd = 5'($urandom_range(0, 7)); p_alu_data = $urandom;
            end
            if (!p_ld && $urandom_range(0, 2) != 0) begin
                p_ld = 1; p_ld_rt = 5'($urandom_range(0, 7)); p_ld_data = $urandom;
                p_ld_op = ops[$urandom_range(0, 7)];
            end
            alu_valid = p_alu; alu_rd = p_alu_rd; alu_data = p_alu_data;
            ld_valid = p_ld; ld_rt = p_ld_rt; ld_data = p_ld_data; ld_opcode = p_ld_op;
            alloc_valid = ($urandom_range(0, 3) == 0);
            alloc_reg = 5'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            step();
            if (m_acc_alu) p_alu = 0;
            if (m_acc_ld) p_ld = 0;
            if (n == 300) begin
                #2;
                apply_reset();
                p_alu = 0; p_ld = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
